// File: rtl/keep_ctrl_pkg.sv
// keep_ctrl_pkg
// Shared types and helpers for the keep_sequencer block.
//   state_t  : controller state (MANUAL / AUTO)
//   SEL_W    : width of the mode select driven to the value/LED block
//   SEL_LAST : last mode code; stepping past it wraps to zero
//   cnt_w()  : width of a counter that holds the values 0..n-1
//   sel_next(): the only legal mode step, 00->01->10->11->00
package keep_ctrl_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_LAST = 2'b11;

  // Counters in this block run 0..n-1, so clog2(n) bits are enough;
  // a one-value counter still needs a single bit to exist.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
    return (s == SEL_LAST) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/keep_debounce.sv
// keep_debounce
// Two-flop synchronizer, debounce counter and press-event generator for
// one raw push button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level, active high
//   evt        : registered one-cycle pulse when the debounced level goes
//                0->1; releases give no pulse
// A level change is accepted after DEBOUNCE_CYC consecutive synced samples
// that disagree with the current debounced level. Any agreeing sample
// restarts the count, so bounces shorter than DEBOUNCE_CYC are ignored.
module keep_debounce
  import keep_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      evt   <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This sample is the DEBOUNCE_CYC-th disagreeing one: accept it.
        level <= sync2;
        cnt   <= '0;
        evt   <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keep_sequencer.sv
// keep_sequencer
// Mode controller for the 4-mode value/LED block.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_next   : raw button, steps the mode
//   btn_mode   : raw button, toggles MANUAL/AUTO
//   sel        : mode select to the value/LED block
//   blink      : LED drive level (constant 1 in MANUAL, square wave in AUTO)
//   auto_on    : registered decode of the AUTO state
//   step_pulse : one-cycle strobe in the cycle sel takes a new value
// step_pulse is a fire-and-forget strobe: it has no ready/acknowledge, and
// the consumer must latch the new sel in the cycle step_pulse is high.
// In MANUAL the mode steps on each debounced btn_next press. In AUTO it
// steps every DWELL_CYC cycles; a btn_next press steps immediately and
// restarts the dwell period. A btn_mode event always wins over a btn_next
// event in the same cycle.
module keep_sequencer
  import keep_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int DWELL_CYC    = 64,
  parameter int BLINK_CYC    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next,
  input  logic             btn_mode,
  output logic [SEL_W-1:0] sel,
  output logic             blink,
  output logic             auto_on,
  output logic             step_pulse
);

  localparam int DW = cnt_w(DWELL_CYC);
  localparam int BW = cnt_w(BLINK_CYC);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  logic          next_evt;
  logic          mode_evt;
  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] blink_cnt;
  logic          dwell_done;
  logic          blink_done;

  keep_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .evt  (next_evt)
  );

  keep_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_mode),
    .evt  (mode_evt)
  );

  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign blink_done = (blink_cnt == BLINK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MANUAL;
      sel        <= '0;
      blink      <= 1'b1;
      auto_on    <= 1'b0;
      step_pulse <= 1'b0;
      dwell_cnt  <= '0;
      blink_cnt  <= '0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        MANUAL: begin
          blink <= 1'b1;
          if (mode_evt) begin
            // next_evt in the same cycle is dropped on purpose.
            state     <= AUTO;
            auto_on   <= 1'b1;
            dwell_cnt <= '0;
            blink_cnt <= '0;
          end else if (next_evt) begin
            sel        <= sel_next(sel);
            step_pulse <= 1'b1;
          end
        end
        AUTO: begin
          if (mode_evt) begin
            state     <= MANUAL;
            auto_on   <= 1'b0;
            blink     <= 1'b1;
            dwell_cnt <= '0;
            blink_cnt <= '0;
          end else begin
            // A press landing on dwell expiry merges into a single step.
            if (next_evt || dwell_done) begin
              sel        <= sel_next(sel);
              step_pulse <= 1'b1;
              dwell_cnt  <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
            if (blink_done) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= MANUAL;
          auto_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keep_sequencer.sv
// tb_keep_sequencer
// Self-checking bench for keep_sequencer with DEBOUNCE_CYC=4, DWELL_CYC=10,
// BLINK_CYC=3. A behavioural model tracks button sample windows, the mode,
// and AUTO timing as edge-count arithmetic from the entry/last-step edges.
module tb_keep_sequencer;

  localparam int D     = 4;
  localparam int DWELL = 10;
  localparam int BLINK = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic [1:0] sel;
  logic       blink;
  logic       auto_on;
  logic       step_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  keep_sequencer #(
    .DEBOUNCE_CYC(D),
    .DWELL_CYC   (DWELL),
    .BLINK_CYC   (BLINK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_next),
    .btn_mode  (btn_mode),
    .sel       (sel),
    .blink     (blink),
    .auto_on   (auto_on),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       edge_n = 0;
  bit [1:0] m_sel;
  bit       m_auto, m_blink, m_step;
  int       m_entry, m_last;
  bit       m_deb_n, m_deb_m, m_evt_n, m_evt_m;
  bit       raw_n[$], raw_m[$], syn_n[$], syn_m[$];

  function automatic void model_reset();
    m_sel = 2'b00; m_auto = 0; m_blink = 1; m_step = 0;
    m_entry = 0; m_last = 0;
    m_deb_n = 0; m_deb_m = 0; m_evt_n = 0; m_evt_m = 0;
    raw_n.delete(); raw_m.delete(); syn_n.delete(); syn_m.delete();
  endfunction

  // True when the last D synced samples all disagree with the debounced level.
  function automatic bit all_differ(input bit q[$], input bit deb);
    if (q.size() < D) return 0;
    foreach (q[i]) if (q[i] == deb) return 0;
    return 1;
  endfunction

  // One rising edge: the FSM acts on events registered at the previous edge,
  // then the debouncers look at the button level sampled two edges ago.
  function automatic void model_edge(input bit bn, input bit bm);
    bit ne, me;
    edge_n++;
    ne = m_evt_n;
    me = m_evt_m;
    m_step = 0;
    if (!m_auto) begin
      if (me) begin
        m_auto = 1; m_entry = edge_n; m_last = edge_n;
      end else if (ne) begin
        m_sel = m_sel + 2'd1; m_step = 1;
      end
    end else begin
      if (me) m_auto = 0;
      else if (ne || (edge_n - m_last) == DWELL) begin
        m_sel = m_sel + 2'd1; m_step = 1; m_last = edge_n;
      end
    end
    m_blink = m_auto ? ((((edge_n - m_entry) / BLINK) % 2) == 0) : 1'b1;

    raw_n.push_back(bn); if (raw_n.size() > 3) void'(raw_n.pop_front());
    raw_m.push_back(bm); if (raw_m.size() > 3) void'(raw_m.pop_front());
    syn_n.push_back(raw_n.size() == 3 ? raw_n[0] : 1'b0);
    syn_m.push_back(raw_m.size() == 3 ? raw_m[0] : 1'b0);
    if (syn_n.size() > D) void'(syn_n.pop_front());
    if (syn_m.size() > D) void'(syn_m.pop_front());
    m_evt_n = 0;
    m_evt_m = 0;
    if (all_differ(syn_n, m_deb_n)) begin m_deb_n = ~m_deb_n; m_evt_n = m_deb_n; end
    if (all_differ(syn_m, m_deb_m)) begin m_deb_m = ~m_deb_m; m_evt_m = m_deb_m; end
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input bit n, input bit m);
    @(negedge clk);
    btn_next = n;
    btn_mode = m;
    @(posedge clk);
    model_edge(n, m);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    btn_next = 1'b0;
    btn_mode = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++; if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel got=%b exp=00", sel); end
    n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL reset_blink got=%b exp=1", blink); end
    n_checks++; if (auto_on !== 1'b0) begin n_fail++; $display("FAIL reset_auto got=%b exp=0", auto_on); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step got=%b exp=0", step_pulse); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual_step();
    int pulses = 0;
    for (int i = 0; i < 22; i++) begin
      tick(i < 12, 1'b0);
      if (step_pulse) pulses++;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL manual edge=%0d got sel=%b blink=%b auto=%b step=%b exp sel=%b blink=%b auto=%b step=%b",
                 edge_n, sel, blink, auto_on, step_pulse, m_sel, m_blink, m_auto, m_step);
      end
      if (i == 6) begin
        n_checks++;
        if ({sel, step_pulse} !== {2'b01, 1'b1}) begin
          n_fail++;
          $display("FAIL manual_latency got sel=%b step=%b exp sel=01 step=1", sel, step_pulse);
        end
      end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL manual_one_pulse got=%0d exp=1", pulses); end
    for (int p = 0; p < 3; p++) begin
      bit [1:0] e;
      e = 2'(p + 2);
      for (int i = 0; i < 16; i++) begin
        tick(i < 6, 1'b0);
        n_checks++;
        if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
          n_fail++;
          $display("FAIL manual_seq edge=%0d got sel=%b step=%b exp sel=%b step=%b", edge_n, sel, step_pulse, m_sel, m_step);
        end
      end
      n_checks++; if (sel !== e) begin n_fail++; $display("FAIL manual_wrap got sel=%b exp=%b", sel, e); end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    bit [1:0] s0;
    s0 = m_sel;
    for (int i = 0; i < 34; i++) begin
      tick((i < 24) && (((i / 2) % 2) == 0), 1'b0);
      if (step_pulse) pulses++;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL bounce edge=%0d got sel=%b step=%b exp sel=%b step=%b", edge_n, sel, step_pulse, m_sel, m_step);
      end
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
    n_checks++; if (sel !== s0) begin n_fail++; $display("FAIL bounce_sel got=%b exp=%b", sel, s0); end
  endtask

  task automatic test_auto();
    int steps = 0;
    int toggles = 0;
    int pulses = 0;
    bit prev_b;
    prev_b = blink;
    for (int i = 0; i < 56; i++) begin
      tick(i < 6, 1'b0 | 1'b0);
      btn_mode = 1'b0;
      if (step_pulse) steps++;
      if (blink !== prev_b) toggles++;
      prev_b = blink;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL auto_run edge=%0d got sel=%b blink=%b auto=%b step=%b exp sel=%b blink=%b auto=%b step=%b",
                 edge_n, sel, blink, auto_on, step_pulse, m_sel, m_blink, m_auto, m_step);
      end
    end
    n_checks++; if (auto_on !== 1'b1) begin n_fail++; $display("FAIL auto_enter got=%b exp=1", auto_on); end
    n_checks++; if (steps != (edge_n - m_entry) / DWELL) begin n_fail++; $display("FAIL auto_steps got=%0d exp=%0d", steps, (edge_n - m_entry) / DWELL); end
    n_checks++; if (toggles != (edge_n - m_entry) / BLINK) begin n_fail++; $display("FAIL auto_blink got=%0d exp=%0d", toggles, (edge_n - m_entry) / BLINK); end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, i < 6);
      if (i >= 10 && step_pulse) pulses++;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL auto_exit edge=%0d got sel=%b blink=%b auto=%b step=%b exp sel=%b blink=%b auto=%b step=%b",
                 edge_n, sel, blink, auto_on, step_pulse, m_sel, m_blink, m_auto, m_step);
      end
    end
    n_checks++; if ({auto_on, blink} !== 2'b01) begin n_fail++; $display("FAIL auto_leave got auto=%b blink=%b exp auto=0 blink=1", auto_on, blink); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL auto_frozen got=%0d pulses exp=0", pulses); end
  endtask

  // Enters AUTO via an initial press of btn_mode; the real auto test above
  // reuses tick() with btn_next only, so drive btn_mode here explicitly.
  task automatic test_collision();
    bit [1:0] s0, s1;
    int coll_edge;
    int step_edges[$];
    bit reached = 0;
    s0 = m_sel;
    for (int i = 0; i < 16; i++) begin
      tick(i < 6, i < 6);
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL coll_manual edge=%0d got sel=%b auto=%b step=%b exp sel=%b auto=%b step=%b", edge_n, sel, auto_on, step_pulse, m_sel, m_auto, m_step);
      end
    end
    n_checks++; if ({auto_on, sel} !== {1'b1, s0}) begin n_fail++; $display("FAIL coll_mode_wins got auto=%b sel=%b exp auto=1 sel=%b", auto_on, sel, s0); end
    // Align a btn_next press so its event meets the dwell terminal cycle.
    for (int g = 0; g < 40; g++) begin
      if (edge_n == m_last + DWELL - 7) begin reached = 1; break; end
      tick(1'b0, 1'b0);
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL coll_align edge=%0d got sel=%b step=%b exp sel=%b step=%b", edge_n, sel, step_pulse, m_sel, m_step);
      end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL coll_align_timeout got edge=%0d exp aligned", edge_n); end
    coll_edge = edge_n + 7;
    s1 = m_sel + 2'd1;
    for (int i = 0; i < 25; i++) begin
      tick(i < 6, 1'b0);
      if (step_pulse) step_edges.push_back(edge_n);
      if (edge_n == coll_edge) begin
        n_checks++;
        if ({sel, step_pulse} !== {s1, 1'b1}) begin n_fail++; $display("FAIL coll_single_step got sel=%b step=%b exp sel=%b step=1", sel, step_pulse, s1); end
      end
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL coll_auto edge=%0d got sel=%b step=%b exp sel=%b step=%b", edge_n, sel, step_pulse, m_sel, m_step);
      end
    end
    n_checks++;
    if (step_edges.size() != 2 || step_edges[0] != coll_edge || step_edges[1] != coll_edge + DWELL) begin
      n_fail++;
      $display("FAIL coll_restart got %0d pulses first=%0d exp pulses at %0d and %0d", step_edges.size(),
               (step_edges.size() > 0) ? step_edges[0] : -1, coll_edge, coll_edge + DWELL);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, i < 6);
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL coll_exit edge=%0d got sel=%b auto=%b exp sel=%b auto=%b", edge_n, sel, auto_on, m_sel, m_auto);
      end
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    for (int i = 0; i < 126; i++) begin
      tick((i < 100) || (i >= 110 && i < 116), 1'b0);
      if (step_pulse) pulses++;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL hold edge=%0d got sel=%b step=%b exp sel=%b step=%b", edge_n, sel, step_pulse, m_sel, m_step);
      end
      if (i == 109) begin
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL hold_one_step got=%0d exp=1", pulses); end
      end
    end
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL hold_second_step got=%0d exp=2", pulses); end
  endtask

  task automatic test_reset_midrun();
    for (int p = 0; p < 4 && m_sel != 2'b10; p++) begin
      for (int i = 0; i < 16; i++) begin
        tick(i < 6, 1'b0);
        n_checks++;
        if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
          n_fail++;
          $display("FAIL rst_prep edge=%0d got sel=%b exp sel=%b", edge_n, sel, m_sel);
        end
      end
    end
    n_checks++; if (sel !== 2'b10) begin n_fail++; $display("FAIL rst_prep_sel got=%b exp=10", sel); end
    // Reset between edges in MANUAL, then again mid-dwell in AUTO.
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        for (int i = 0; i < 22; i++) tick(1'b0, i < 6);
        n_checks++; if (auto_on !== 1'b1) begin n_fail++; $display("FAIL rst_auto_prep got=%b exp=1", auto_on); end
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== 5'b00_1_0_0) begin
        n_fail++;
        $display("FAIL rst_async got sel=%b blink=%b auto=%b step=%b exp sel=00 blink=1 auto=0 step=0", sel, blink, auto_on, step_pulse);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      int kind, len;
      kind = $urandom_range(0, 4);
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        bit n, m;
        n = (kind == 1 || kind == 4) || (kind == 3 && $urandom_range(0, 1) == 1);
        m = (kind == 2 || kind == 4);
        tick(n, m);
        n_checks++;
        if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
          n_fail++;
          $display("FAIL random edge=%0d got sel=%b blink=%b auto=%b step=%b exp sel=%b blink=%b auto=%b step=%b",
                   edge_n, sel, blink, auto_on, step_pulse, m_sel, m_blink, m_auto, m_step);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_step();
    test_bounce();
    // Enter AUTO with a clean btn_mode press, observe, then leave.
    for (int i = 0; i < 1; i++) begin end
    test_auto_entry();
    test_collision();
    test_hold();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // AUTO scenario driven with btn_mode.
  task automatic test_auto_entry();
    int steps = 0;
    int toggles = 0;
    int pulses = 0;
    bit prev_b;
    prev_b = blink;
    for (int i = 0; i < 56; i++) begin
      tick(1'b0, i < 6);
      if (step_pulse) steps++;
      if (blink !== prev_b) toggles++;
      prev_b = blink;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL auto_run edge=%0d got sel=%b blink=%b auto=%b step=%b exp sel=%b blink=%b auto=%b step=%b",
                 edge_n, sel, blink, auto_on, step_pulse, m_sel, m_blink, m_auto, m_step);
      end
    end
    n_checks++; if (auto_on !== 1'b1) begin n_fail++; $display("FAIL auto_enter got=%b exp=1", auto_on); end
    n_checks++; if (steps != (edge_n - m_entry) / DWELL) begin n_fail++; $display("FAIL auto_steps got=%0d exp=%0d", steps, (edge_n - m_entry) / DWELL); end
    n_checks++; if (toggles != (edge_n - m_entry) / BLINK) begin n_fail++; $display("FAIL auto_blink got=%0d exp=%0d", toggles, (edge_n - m_entry) / BLINK); end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, i < 6);
      if (i >= 10 && step_pulse) pulses++;
      n_checks++;
      if ({sel, blink, auto_on, step_pulse} !== {m_sel, m_blink, m_auto, m_step}) begin
        n_fail++;
        $display("FAIL auto_exit edge=%0d got sel=%b blink=%b auto=%b step=%b exp sel=%b blink=%b auto=%b step=%b",
                 edge_n, sel, blink, auto_on, step_pulse, m_sel, m_blink, m_auto, m_step);
      end
    end
    n_checks++; if ({auto_on, blink} !== 2'b01) begin n_fail++; $display("FAIL auto_leave got auto=%b blink=%b exp auto=0 blink=1", auto_on, blink); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL auto_frozen got=%0d pulses exp=0", pulses); end
  endtask

endmodule

// File: doc/keep_sequencer.md
Name: keep_sequencer

Overview:
Controller for the 4-mode value/LED block. It generates that block's 2-bit mode select and its LED drive level from two push buttons.
- Manual mode: the sequencer steps the mode on each debounced press.
- Auto mode: it steps the mode on a dwell timer.
- It also generates a blink level for the LED input and a one-cycle strobe on every mode change, so downstream logic can latch the new output value.

Parameters:
- DEBOUNCE_CYC, 16, consecutive stable synced samples needed to accept a button level change (>=2).
- DWELL_CYC, 64, cycles per mode in AUTO (>=2).
- BLINK_CYC, 8, cycles per blink half-period in AUTO (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset.
- btn_next  in  1  raw asynchronous push button, active high: step mode.
- btn_mode  in  1  raw asynchronous push button, active high: toggle MANUAL/AUTO.
- sel  out  2  mode select to the value/LED block (00..11).
- blink  out  1  LED drive level to the value/LED block.
- auto_on  out  1  high while in AUTO.
- step_pulse  out  1  one-cycle strobe in the cycle sel takes a new value.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset is asynchronous on assertion and clears all state immediately, including mid-step or mid-dwell:
  - sel=00, blink=1, auto_on=0, step_pulse=0.
  - State=MANUAL; all counters and sync/debounce flops = 0.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debounce, per button:
  - A counter increments while the synced level differs from the debounced level.
  - The counter clears whenever the synced level equals the debounced level.
  - When the count reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
  - A registered event pulse (1 cycle) fires on a 0->1 flip of the debounced level only.
  - Releases produce no event.
- Latency: for a clean press, the event is high on edge 2+DEBOUNCE_CYC after the first edge sampling btn=1. sel/step_pulse update on the following edge.
- FSM states: MANUAL, AUTO.
  - MANUAL:
    - next_evt: sel <= sel+1 (mod 4), step_pulse=1.
    - mode_evt: go to AUTO; clear dwell and blink counters; blink <= 1.
  - AUTO:
    - The dwell counter counts 0..DWELL_CYC-1. At DWELL_CYC-1: sel <= sel+1, step_pulse=1, counter <= 0.
    - next_evt: immediate sel+1, step_pulse=1, dwell counter <= 0.
    - mode_evt: go to MANUAL; blink <= 1 and held; sel unchanged.
- Blink:
  - In AUTO, a counter counts 0..BLINK_CYC-1 and toggles blink at the terminal count.
  - In MANUAL, blink is constant 1.
- Wrap-around: sel 11 -> 00; no other sequence is allowed.
- Simultaneous events:
  - mode_evt and next_evt in the same cycle: mode toggle wins, next_evt is discarded, sel unchanged.
  - next_evt coinciding with dwell expiry: exactly one increment and one step_pulse; dwell restarts at 0.
- step_pulse is never high for 2 consecutive cycles unless two distinct triggers occur in consecutive cycles.
- Holding a button produces one event; the button must release (debounced) before the next event.
- auto_on is a registered decode of the state.

Decomposition:
- Package keep_ctrl_pkg:
  - State enum {MANUAL, AUTO}.
  - SEL_W=2 and SEL_LAST=2'b11.
  - Counter-width helper (clog2-based) used for the debounce, dwell and blink counters.
- Sub-module keep_debounce (2-flop sync + debounce counter + rising-edge event), parameterised by DEBOUNCE_CYC. It is instantiated twice.
- The top level holds the FSM, the dwell and blink counters, and the output registers.

Test Plan (bench parameters DEBOUNCE_CYC=4, DWELL_CYC=10, BLINK_CYC=3):
- Reset: rst_n=0 at time 0 -> sel=00, blink=1, auto_on=0, step_pulse=0. Drive to sel=10, then pulse rst_n low between edges -> outputs clear before the next edge.
- Manual step: btn_next high 12 cycles -> one step_pulse, sel 00->01 on edge 7 after press. Four clean presses -> sel 01,10,11,00.
- Bounce rejection: btn_next toggling every 2 cycles for 24 cycles, then low -> no event, sel unchanged, step_pulse never high.
- Auto run: clean btn_mode press -> auto_on=1; sel increments every 10 cycles with step_pulse each time; blink toggles every 3 cycles. A second btn_mode press -> auto_on=0, blink=1, sel frozen.
- Collisions:
  - next and mode events forced in the same cycle in MANUAL -> AUTO entered, sel unchanged.
  - In AUTO, next event on dwell terminal cycle -> single increment; the next auto step occurs 10 cycles later.
- Hold: btn_next held 100 cycles -> exactly one step. Release, then press again -> second step.
